// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: producer/consumer bundle for fifo_sync_param.
// master = the side driving write/read requests, slave = the FIFO itself.
interface fifo_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             clear;
  logic             write;
  logic [WIDTH-1:0] data_in;
  logic             read;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, write, data_in, read,
    input  data_out, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  clear, write, data_in, read,
    output data_out, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO, power-of-two DEPTH, wrap-around
// pointers, occupancy count, almost thresholds, sticky error flags, sync clear.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is
// loaded on the edge where a read is accepted.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic              clk,
  input logic              reset,
  fifo_sync_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             ae_q, ae_d, af_q, af_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_acc, rd_acc;

  // Acceptance, pointer/count/flag next state; status derived from count_d
  // so registered flags always agree with the registered count.
  always_comb begin
    rd_acc   = bus.read & ~empty_q & ~bus.clear;
    wr_acc   = bus.write & (~full_q | rd_acc) & ~bus.clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (bus.write & ~wr_acc) ovf_d = 1'b1;
      if (bus.read & empty_q)  unf_d = 1'b1;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);
    ae_d    = (count_d <= AE_C);
    af_d    = (count_d >= AF_C);
  end

  // Read data next state.
  always_comb begin
    dout_d = dout_q;
`ifdef FIFO_FWFT_EN
    // Present the head word after every edge; a word written this cycle into
    // the head slot is not in mem_q yet, so forward it from data_in.
    if (!bus.clear && count_d != '0) begin
      if (wr_acc && wr_ptr_q == rd_ptr_d) dout_d = bus.data_in;
      else                                dout_d = mem_q[rd_ptr_d];
    end
`else
    if (rd_acc) dout_d = mem_q[rd_ptr_q];
`endif
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ae_q     <= ae_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed scoreboard bench, WIDTH=8 DEPTH=4 AF=2 AE=1.
// Read-data checks adapt to FIFO_FWFT_EN.
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];
  logic fire_prev = 1'b0;

  fifo_sync_param_if #(.WIDTH(8), .DEPTH(4)) bus ();

  fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(2), .AE_LEVEL(1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // status = {count, empty, full, almost_empty, almost_full, overflow, underflow}
  task automatic st(input string name, input int c, input bit e, input bit f,
                    input bit ae, input bit af, input bit ov, input bit un);
    logic [31:0] act, exp;
    act = {23'b0, bus.count, bus.empty, bus.full, bus.almost_empty,
           bus.almost_full, bus.overflow, bus.underflow};
    exp = {23'b0, 3'(c), e, f, ae, af, ov, un};
    chk(name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.write = 1'b1; bus.data_in = d;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] exp);
    exp_q.push_back(exp);
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
  endtask

  task automatic pop_check();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL rd_data: unexpected pop, data_out %0h", bus.data_out);
    end else begin
      e = exp_q.pop_front();
      chk("rd_data", 32'(bus.data_out), 32'(e));
    end
  endtask

  // Monitor: compare read data whenever the DUT delivers a popped word.
  always @(negedge clk) begin
    if (!reset) begin
      fire_prev = 1'b0;
    end else begin
`ifdef FIFO_FWFT_EN
      if (bus.read && !bus.empty && !bus.clear) pop_check();
`else
      if (fire_prev) pop_check();
      fire_prev = bus.read && !bus.empty && !bus.clear;
`endif
    end
  end

  initial begin
    bus.clear = 1'b0; bus.write = 1'b0; bus.read = 1'b0; bus.data_in = '0;
    repeat (2) tick();
    st("reset_state", 0, 1, 0, 1, 0, 0, 0);
    chk("reset_dout", 32'(bus.data_out), 32'h0);
    reset = 1'b1;
    tick();

    // fill / drain with wrap
    wr(8'h11); st("one_word", 1, 0, 0, 1, 0, 0, 0);
    wr(8'h22); st("af_level", 2, 0, 0, 0, 1, 0, 0);
    wr(8'h33); wr(8'h44);
    st("fill_full", 4, 0, 1, 0, 1, 0, 0);
    rd(8'h11); rd(8'h22);
    st("part_drain", 2, 0, 0, 0, 1, 0, 0);
    wr(8'h55); wr(8'h66);
    st("wrap_full", 4, 0, 1, 0, 1, 0, 0);
    rd(8'h33); rd(8'h44); rd(8'h55); rd(8'h66);
    st("drained", 0, 1, 0, 1, 0, 0, 0);

    // simultaneous read/write at full
    wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
    exp_q.push_back(8'h01);
    bus.read = 1'b1; bus.write = 1'b1; bus.data_in = 8'hAA;
    tick();
    bus.read = 1'b0; bus.write = 1'b0;
    st("full_rw", 4, 0, 1, 0, 1, 0, 0);
    rd(8'h02); rd(8'h03); rd(8'h04); rd(8'hAA);
    st("full_rw_drain", 0, 1, 0, 1, 0, 0, 0);

    // simultaneous read/write at empty
    bus.read = 1'b1; bus.write = 1'b1; bus.data_in = 8'h5A;
    tick();
    bus.read = 1'b0; bus.write = 1'b0;
    st("empty_rw", 1, 0, 0, 1, 0, 0, 1);
`ifdef FIFO_FWFT_EN
    chk("fwft_head_5a", 32'(bus.data_out), 32'h5A);
`endif
    rd(8'h5A);
    st("empty_rw_drain", 0, 1, 0, 1, 0, 0, 1);

    // overflow, then clear with read & write
    wr(8'h71); wr(8'h72); wr(8'h73); wr(8'h74);
    wr(8'h77);
    st("overflow", 4, 0, 1, 0, 1, 1, 1);
    rd(8'h71); rd(8'h72); rd(8'h73); rd(8'h74);
    st("ovf_drain", 0, 1, 0, 1, 0, 1, 1);
    wr(8'h81); wr(8'h82);
    bus.clear = 1'b1; bus.read = 1'b1; bus.write = 1'b1; bus.data_in = 8'h99;
    tick();
    bus.clear = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    st("clear", 0, 1, 0, 1, 0, 0, 0);

    // write into empty with no read
    wr(8'h3C);
    st("post_clear_wr", 1, 0, 0, 1, 0, 0, 0);
`ifdef FIFO_FWFT_EN
    chk("fwft_fallthru", 32'(bus.data_out), 32'h3C);
`else
    chk("dout_hold", 32'(bus.data_out), 32'h74);
`endif
    rd(8'h3C);
    st("post_clear_rd", 0, 1, 0, 1, 0, 0, 0);
    chk("dout_after_pop", 32'(bus.data_out), 32'h3C);

    // asynchronous reset in the middle of a burst
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    st("pre_reset", 3, 0, 0, 0, 1, 0, 0);
    bus.write = 1'b1; bus.data_in = 8'hA4;
    #2 reset = 1'b0;
    #1;
    st("async_reset", 0, 1, 0, 1, 0, 0, 0);
    chk("async_reset_dout", 32'(bus.data_out), 32'h0);
    tick();
    st("reset_held", 0, 1, 0, 1, 0, 0, 0);
    bus.write = 1'b0;
    reset = 1'b1;
    tick();
    wr(8'hB7);
    st("after_reset_wr", 1, 0, 0, 1, 0, 0, 0);
    rd(8'hB7);
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
